id_ex_stage: RTL

- ID/EX pipeline register directly downstream of the instruction-decode controller.
- Captures the decoded control flags and ID operands, and presents them to the execute stage one cycle later.
- Detects load-use hazards, inserting a bubble and stalling the front end.
- Squashes the instruction on a taken-branch/jump flush, and latches a sticky halt when a HALT instruction reaches EX.

---
 rtl/id_ex_stage.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush squashing
// and sticky halt capture.
module id_ex_stage #(
   parameter int DATA_W = 32,
   parameter int PC_W   = 9,
   parameter int REG_W  = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              id_ALUSrc,
   input  logic              id_MemtoReg,
   input  logic              id_RegWrite,
   input  logic              id_MemRead,
   input  logic              id_MemWrite,
   input  logic              id_Branch,
   input  logic              id_Halt,
   input  logic              id_Jal,
   input  logic              id_Jalr,
   input  logic [1:0]        id_ALUOp,
   input  logic [PC_W-1:0]   id_pc,
   input  logic [DATA_W-1:0] id_rd1,
   input  logic [DATA_W-1:0] id_rd2,
   input  logic [DATA_W-1:0] id_imm,
   input  logic [REG_W-1:0]  id_rs1,
   input  logic [REG_W-1:0]  id_rs2,
   input  logic [REG_W-1:0]  id_rd,
   input  logic [2:0]        id_funct3,
   input  logic [6:0]        id_funct7,
   input  logic              flush,
   output logic              ex_ALUSrc,
   output logic              ex_MemtoReg,
   output logic              ex_RegWrite,
   output logic              ex_MemRead,
   output logic              ex_MemWrite,
   output logic              ex_Branch,
   output logic              ex_Jal,
   output logic              ex_Jalr,
   output logic [1:0]        ex_ALUOp,
   output logic [PC_W-1:0]   ex_pc,
   output logic [DATA_W-1:0] ex_rd1,
   output logic [DATA_W-1:0] ex_rd2,
   output logic [DATA_W-1:0] ex_imm,
   output logic [REG_W-1:0]  ex_rs1,
   output logic [REG_W-1:0]  ex_rs2,
   output logic [REG_W-1:0]  ex_rd,
   output logic [2:0]        ex_funct3,
   output logic [6:0]        ex_funct7,
   output logic              stall,
   output logic              halted
);

   logic              r_ALUSrc, r_MemtoReg, r_RegWrite, r_MemRead;
   logic              r_MemWrite, r_Branch, r_Jal, r_Jalr, r_halted;
   logic [1:0]        r_ALUOp;
   logic [PC_W-1:0]   r_pc;
   logic [DATA_W-1:0] r_rd1, r_rd2, r_imm;
   logic [REG_W-1:0]  r_rs1, r_rs2, r_rd;
   logic [2:0]        r_funct3;
   logic [6:0]        r_funct7;

   logic w_hazard, w_load, w_set_halt, w_stall;

   // Hazard detection and load selection; a Halt reaching EX is replaced by a bubble.
   always_comb begin
      w_hazard   = 1'b0;
      w_load     = 1'b0;
      w_set_halt = 1'b0;
      w_stall    = 1'b0;
      if (r_MemRead && (r_rd != {REG_W{1'b0}}) && ((r_rd == id_rs1) || (r_rd == id_rs2))) begin
         w_hazard = 1'b1;
      end else begin
         w_hazard = 1'b0;
      end
      if (!r_halted && !flush && !w_hazard) begin
         w_load     = !id_Halt;
         w_set_halt = id_Halt;
      end else begin
         w_load     = 1'b0;
         w_set_halt = 1'b0;
      end
      w_stall = (w_hazard && !flush) || r_halted;
   end

   // Pipeline register: ID contents or a zero bubble every edge; halt is sticky.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ALUSrc   <= 1'b0;
         r_MemtoReg <= 1'b0;
         r_RegWrite <= 1'b0;
         r_MemRead  <= 1'b0;
         r_MemWrite <= 1'b0;
         r_Branch   <= 1'b0;
         r_Jal      <= 1'b0;
         r_Jalr     <= 1'b0;
         r_ALUOp    <= 2'b00;
         r_pc       <= {PC_W{1'b0}};
         r_rd1      <= {DATA_W{1'b0}};
         r_rd2      <= {DATA_W{1'b0}};
         r_imm      <= {DATA_W{1'b0}};
         r_rs1      <= {REG_W{1'b0}};
         r_rs2      <= {REG_W{1'b0}};
         r_rd       <= {REG_W{1'b0}};
         r_funct3   <= 3'b000;
         r_funct7   <= 7'b0000000;
         r_halted   <= 1'b0;
      end else begin
         if (w_load) begin
            r_ALUSrc   <= id_ALUSrc;
            r_MemtoReg <= id_MemtoReg;
            r_RegWrite <= id_RegWrite;
            r_MemRead  <= id_MemRead;
            r_MemWrite <= id_MemWrite;
            r_Branch   <= id_Branch;
            r_Jal      <= id_Jal;
            r_Jalr     <= id_Jalr;
            r_ALUOp    <= id_ALUOp;
            r_pc       <= id_pc;
            r_rd1      <= id_rd1;
            r_rd2      <= id_rd2;
            r_imm      <= id_imm;
            r_rs1      <= id_rs1;
            r_rs2      <= id_rs2;
            r_rd       <= id_rd;
            r_funct3   <= id_funct3;
            r_funct7   <= id_funct7;
         end else begin
            r_ALUSrc   <= 1'b0;
            r_MemtoReg <= 1'b0;
            r_RegWrite <= 1'b0;
            r_MemRead  <= 1'b0;
            r_MemWrite <= 1'b0;
            r_Branch   <= 1'b0;
            r_Jal      <= 1'b0;
            r_Jalr     <= 1'b0;
            r_ALUOp    <= 2'b00;
            r_pc       <= {PC_W{1'b0}};
            r_rd1      <= {DATA_W{1'b0}};
            r_rd2      <= {DATA_W{1'b0}};
            r_imm      <= {DATA_W{1'b0}};
            r_rs1      <= {REG_W{1'b0}};
            r_rs2      <= {REG_W{1'b0}};
            r_rd       <= {REG_W{1'b0}};
            r_funct3   <= 3'b000;
            r_funct7   <= 7'b0000000;
         end
         if (w_set_halt) begin
            r_halted <= 1'b1;
         end else begin
            r_halted <= r_halted;
         end
      end
   end

   assign ex_ALUSrc   = r_ALUSrc;
   assign ex_MemtoReg = r_MemtoReg;
   assign ex_RegWrite = r_RegWrite;
   assign ex_MemRead  = r_MemRead;
   assign ex_MemWrite = r_MemWrite;
   assign ex_Branch   = r_Branch;
   assign ex_Jal      = r_Jal;
   assign ex_Jalr     = r_Jalr;
   assign ex_ALUOp    = r_ALUOp;
   assign ex_pc       = r_pc;
   assign ex_rd1      = r_rd1;
   assign ex_rd2      = r_rd2;
   assign ex_imm      = r_imm;
   assign ex_rs1      = r_rs1;
   assign ex_rs2      = r_rs2;
   assign ex_rd       = r_rd;
   assign ex_funct3   = r_funct3;
   assign ex_funct7   = r_funct7;
   assign stall       = w_stall;
   assign halted      = r_halted;

endmodule
